// File: rtl/game_net_pkg.sv
// Shared definitions for the kart network link.
// Both the receive parser and the transmit packet builder import this package.
// Contents:
//   - packet length and default sync byte;
//   - opponent state field widths and the direction limit;
//   - game status encoding;
//   - receive FSM state encoding.
package game_net_pkg;

    localparam int          PKT_LEN       = 8;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    localparam int X_W     = 11;
    localparam int Y_W     = 11;
    localparam int DIR_W   = 9;
    localparam int GAME_W  = 3;
    localparam int DIR_MAX = 359;

    // Payload bytes between seq and checksum.
    localparam int PAYLOAD_BYTES = PKT_LEN - 3;

    typedef enum logic [GAME_W-1:0] {
        GS_WAIT = 3'd0,
        GS_RACE = 3'd1,
        GS_WON  = 3'd2
    } game_status_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SEQ,
        RX_PAYLOAD,
        RX_CSUM,
        RX_DROP
    } rx_state_t;

endpackage

// File: rtl/opp_packet_rx_if.sv
// Byte stream from the network receive path into the opponent packet parser.
// Signals:
//   axiiv    - byte valid
//   axiid    - byte
//   axiilast - last byte of a frame, qualified by axiiv
// Modports:
//   master - the receive path driving the stream
//   slave  - the parser consuming it
interface opp_packet_rx_if;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiilast;

    modport master (output axiiv, output axiid, output axiilast);
    modport slave  (input  axiiv, input  axiid, input  axiilast);
endinterface

// File: rtl/link_watchdog.sv
// Link-loss watchdog.
// Counts cycles since the last accepted packet, saturating at TIMEOUT_CYCLES.
// link_lost is high while the counter sits at the limit.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   kick      - an accepted packet; clears the counter
//   link_lost - timeout expired
module link_watchdog #(
    parameter int TIMEOUT_CYCLES = 6_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic link_lost
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || kick) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Combinational from the counter so it drops in the same cycle the
    // accepting packet's axiov pulse appears.
    assign link_lost = (cnt == LIMIT);

endmodule

// File: rtl/opp_packet_rx.sv
// Opponent packet receiver.
// Parses 8-byte packets from the network byte stream:
//   SYNC, seq, 5 payload bytes, XOR checksum of seq..payload.
// Validated packets update the opponent state and pulse axiov.
// Ports:
//   clk           - clock
//   btnc          - synchronous active-high reset
//   rx            - byte stream (axiiv/axiid/axiilast)
//   axiov         - one-cycle pulse, new opponent state
//   opp_x         - opponent x
//   opp_y         - opponent y
//   opp_dir       - opponent direction
//   opp_game      - opponent game status
//   link_lost     - no accepted packet within TIMEOUT_CYCLES
//   pkt_ok_count  - accepted packets, wrapping
//   pkt_err_count - rejected packets, saturating
module opp_packet_rx
    import game_net_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 6_500_000,
    parameter int         RESET_X        = 300,
    parameter int         RESET_Y        = 100,
    parameter int         RESET_DIR      = 90
) (
    input  logic              clk,
    input  logic              btnc,
    opp_packet_rx_if.slave    rx,
    output logic              axiov,
    output logic [X_W-1:0]    opp_x,
    output logic [Y_W-1:0]    opp_y,
    output logic [DIR_W-1:0]  opp_dir,
    output logic [GAME_W-1:0] opp_game,
    output logic              link_lost,
    output logic [7:0]        pkt_ok_count,
    output logic [7:0]        pkt_err_count
);

    rx_state_t  state, state_nx;
    logic [7:0] xor_acc;
    logic [2:0] byte_cnt;
    logic [7:0] seq_r;
    logic [7:0] last_seq;
    logic       last_seq_vld;
    // Only the 34 meaningful payload bits are kept; the 6 pad bits of the
    // final payload byte are never stored.
    logic [33:0] payload;

    logic accept;
    logic reject_err;

    wire [X_W-1:0]    f_x    = payload[33:23];
    wire [Y_W-1:0]    f_y    = payload[22:12];
    wire [DIR_W-1:0]  f_dir  = payload[11:3];
    wire [GAME_W-1:0] f_game = payload[2:0];

    wire csum_ok   = (rx.axiid == xor_acc);
    wire fields_ok = (f_dir <= DIR_W'(DIR_MAX)) && (f_game <= GAME_W'(GS_WON));
    wire dup_seq   = last_seq_vld && (seq_r == last_seq);
    wire last_pay  = (byte_cnt == 3'(PAYLOAD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (btnc) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        reject_err = 1'b0;
        if (rx.axiiv) begin
            case (state)
                RX_IDLE: begin
                    if (rx.axiid == SYNC_BYTE) begin
                        if (rx.axiilast) reject_err = 1'b1;
                        else             state_nx   = RX_SEQ;
                    end
                end
                RX_SEQ: begin
                    if (rx.axiilast) begin
                        reject_err = 1'b1;
                        state_nx   = RX_IDLE;
                    end else begin
                        state_nx = RX_PAYLOAD;
                    end
                end
                RX_PAYLOAD: begin
                    if (rx.axiilast) begin
                        reject_err = 1'b1;
                        state_nx   = RX_IDLE;
                    end else if (last_pay) begin
                        state_nx = RX_CSUM;
                    end
                end
                RX_CSUM: begin
                    // A duplicate of an otherwise good packet is dropped
                    // quietly; it is not a link error.
                    if (csum_ok && fields_ok) accept     = !dup_seq;
                    else                      reject_err = 1'b1;
                    state_nx = rx.axiilast ? RX_IDLE : RX_DROP;
                end
                RX_DROP: begin
                    if (rx.axiilast) state_nx = RX_IDLE;
                end
                default: state_nx = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (btnc) begin
            xor_acc  <= '0;
            byte_cnt <= '0;
        end else if (rx.axiiv) begin
            if (state == RX_SEQ) begin
                xor_acc  <= rx.axiid;
                byte_cnt <= '0;
            end else if (state == RX_PAYLOAD) begin
                xor_acc  <= xor_acc ^ rx.axiid;
                byte_cnt <= byte_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx.axiiv && state == RX_SEQ) begin
            seq_r <= rx.axiid;
        end
        if (rx.axiiv && state == RX_PAYLOAD) begin
            if (last_pay) payload <= {payload[31:0], rx.axiid[7:6]};
            else          payload <= {payload[25:0], rx.axiid};
        end
    end

    always_ff @(posedge clk) begin
        if (btnc) begin
            axiov         <= 1'b0;
            opp_x         <= X_W'(RESET_X);
            opp_y         <= Y_W'(RESET_Y);
            opp_dir       <= DIR_W'(RESET_DIR);
            opp_game      <= GAME_W'(GS_WAIT);
            last_seq      <= '0;
            last_seq_vld  <= 1'b0;
            pkt_ok_count  <= '0;
            pkt_err_count <= '0;
        end else begin
            axiov <= accept;
            if (accept) begin
                opp_x        <= f_x;
                opp_y        <= f_y;
                opp_dir      <= f_dir;
                opp_game     <= f_game;
                last_seq     <= seq_r;
                last_seq_vld <= 1'b1;
                pkt_ok_count <= pkt_ok_count + 8'd1;
            end
            if (reject_err && pkt_err_count != 8'hFF) begin
                pkt_err_count <= pkt_err_count + 8'd1;
            end
        end
    end

    link_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (btnc),
        .kick      (accept),
        .link_lost (link_lost)
    );

endmodule

// File: tb/tb_opp_packet_rx.sv
module tb_opp_packet_rx;
    import game_net_pkg::*;

    logic              clk = 1'b0;
    logic              btnc;
    logic              axiov;
    logic [X_W-1:0]    opp_x;
    logic [Y_W-1:0]    opp_y;
    logic [DIR_W-1:0]  opp_dir;
    logic [GAME_W-1:0] opp_game;
    logic              link_lost;
    logic [7:0]        pkt_ok_count;
    logic [7:0]        pkt_err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt [8];
    int ex, ey, edir, egame;

    opp_packet_rx_if bus ();

    opp_packet_rx #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (20),
        .RESET_X        (0),
        .RESET_Y        (0),
        .RESET_DIR      (0)
    ) dut (
        .clk           (clk),
        .btnc          (btnc),
        .rx            (bus.slave),
        .axiov         (axiov),
        .opp_x         (opp_x),
        .opp_y         (opp_y),
        .opp_dir       (opp_dir),
        .opp_game      (opp_game),
        .link_lost     (link_lost),
        .pkt_ok_count  (pkt_ok_count),
        .pkt_err_count (pkt_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_lit(input logic [63:0] v);
        for (int i = 0; i < 8; i++) pkt[i] = v[63 - 8*i -: 8];
    endtask

    // Packs fields MSB first into the 40-bit payload and appends the XOR.
    task automatic build(input logic [7:0] seq, input int x, input int y,
                         input int dir, input int game);
        logic [39:0] p;
        logic [7:0]  c;
        p = {x[10:0], y[10:0], dir[8:0], game[2:0], 6'b0};
        pkt[0] = 8'hA5;
        pkt[1] = seq;
        for (int i = 0; i < 5; i++) pkt[2+i] = p[39 - 8*i -: 8];
        c = seq;
        for (int i = 2; i < 7; i++) c = c ^ pkt[i];
        pkt[7] = c;
    endtask

    // Drives nbytes of pkt, axiilast on index last_at (-1: none), with gap
    // idle cycles before each byte. Returns one cycle after the last byte.
    task automatic send(input int gap, input int last_at, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            repeat (gap) begin
                @(negedge clk);
                bus.axiiv = 1'b0;
            end
            @(negedge clk);
            bus.axiiv    = 1'b1;
            bus.axiid    = pkt[i];
            bus.axiilast = (i == last_at);
        end
        @(negedge clk);
        bus.axiiv    = 1'b0;
        bus.axiilast = 1'b0;
    endtask

    task automatic raw_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        bus.axiiv    = 1'b1;
        bus.axiid    = b;
        bus.axiilast = last;
        @(negedge clk);
        bus.axiiv    = 1'b0;
        bus.axiilast = 1'b0;
    endtask

    task automatic expect_accept(input string tag, input int x, input int y,
                                 input int dir, input int game, input int ok);
        chk({tag, "_axiov"}, axiov, 1);
        chk({tag, "_link"}, link_lost, 0);
        chk({tag, "_x"}, opp_x, x);
        chk({tag, "_y"}, opp_y, y);
        chk({tag, "_dir"}, opp_dir, dir);
        chk({tag, "_game"}, opp_game, game);
        chk({tag, "_ok"}, pkt_ok_count, ok);
        ex = x; ey = y; edir = dir; egame = game;
        tick(1);
        chk({tag, "_pulse1"}, axiov, 0);
    endtask

    task automatic expect_reject(input string tag, input int err);
        chk({tag, "_axiov0"}, axiov, 0);
        tick(1);
        chk({tag, "_axiov1"}, axiov, 0);
        chk({tag, "_err"}, pkt_err_count, err);
        chk({tag, "_x"}, opp_x, ex);
        chk({tag, "_dir"}, opp_dir, edir);
    endtask

    initial begin
        btnc         = 1'b1;
        bus.axiiv    = 1'b0;
        bus.axiid    = 8'h00;
        bus.axiilast = 1'b0;
        ex = 0; ey = 0; edir = 0; egame = 0;
        tick(2);
        btnc = 1'b0;

        // Reset state
        chk("rst_axiov", axiov, 0);
        chk("rst_x", opp_x, 0);
        chk("rst_y", opp_y, 0);
        chk("rst_dir", opp_dir, 0);
        chk("rst_game", opp_game, 0);
        chk("rst_ok", pkt_ok_count, 0);
        chk("rst_err", pkt_err_count, 0);
        chk("rst_link", link_lost, 0);

        // Watchdog: 20 idle cycles to expiry
        tick(19);
        chk("wd_19", link_lost, 0);
        tick(1);
        chk("wd_20", link_lost, 1);

        // Bad checksum
        load_lit(64'hA5_01_25_81_92_B4_40_C2);
        send(0, 7, 8);
        expect_reject("badcsum", 1);

        // Reference vector; its dir field decodes to 346
        chk("link_before", link_lost, 1);
        load_lit(64'hA5_01_25_81_92_B4_40_C3);
        send(0, 7, 8);
        expect_accept("lit", 300, 100, 346, 1, 1);

        // Duplicate seq: dropped, not an error
        send(0, 7, 8);
        expect_reject("dup", 1);
        chk("dup_ok", pkt_ok_count, 1);

        load_lit(64'hA5_02_25_81_92_B4_40_C0);
        send(0, 7, 8);
        expect_accept("seq2", 300, 100, 346, 1, 2);

        // Junk before sync, 3-cycle gaps between bytes
        raw_byte(8'h00, 1'b0);
        raw_byte(8'hFF, 1'b0);
        raw_byte(8'h13, 1'b1);
        build(8'h03, 5, 7, 90, 2);
        send(3, 7, 8);
        expect_accept("gaps", 5, 7, 90, 2, 3);

        // Field limits
        build(8'h04, 1, 1, 360, 0);
        send(0, 7, 8);
        expect_reject("dir360", 2);
        build(8'h05, 1, 1, 10, 3);
        send(0, 7, 8);
        expect_reject("game3", 3);
        build(8'h06, 2047, 0, 359, 0);
        send(0, 7, 8);
        expect_accept("dir359", 2047, 0, 359, 0, 4);

        // Early end on B4
        build(8'h07, 9, 9, 9, 1);
        send(0, 4, 5);
        expect_reject("early", 4);
        build(8'h08, 1, 2, 3, 1);
        send(0, 7, 8);
        expect_accept("after_early", 1, 2, 3, 1, 5);

        // No axiilast on B7: accepted, trailing bytes dropped
        build(8'h09, 10, 20, 30, 0);
        send(0, -1, 8);
        expect_accept("nolast", 10, 20, 30, 0, 6);
        raw_byte(8'hA5, 1'b0);
        raw_byte(8'h00, 1'b1);
        chk("drop_err", pkt_err_count, 4);
        build(8'h0A, 100, 200, 300, 2);
        send(0, 7, 8);
        expect_accept("after_drop", 100, 200, 300, 2, 7);

        // Reset in the middle of a packet
        build(8'h0B, 7, 7, 7, 1);
        send(0, -1, 4);
        btnc = 1'b1;
        tick(1);
        btnc = 1'b0;
        chk("mrst_x", opp_x, 0);
        chk("mrst_dir", opp_dir, 0);
        chk("mrst_ok", pkt_ok_count, 0);
        chk("mrst_err", pkt_err_count, 0);
        chk("mrst_link", link_lost, 0);
        ex = 0; ey = 0; edir = 0; egame = 0;
        // Same seq as the last packet before reset: duplicate filter is cleared
        build(8'h0A, 100, 200, 300, 2);
        send(0, 7, 8);
        expect_accept("post_rst", 100, 200, 300, 2, 1);

        // Error counter saturation: sync+last is an error every time
        for (int i = 0; i < 260; i++) raw_byte(8'hA5, 1'b1);
        chk("err_sat", pkt_err_count, 255);
        chk("sat_ok", pkt_ok_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
